// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters plus special-register locks.
// Gives decode lock/allow decisions, with a same-cycle writeback bypass on the allow paths.
module reg_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2,
  parameter int unsigned NSP  = 6,
  parameter int unsigned CW   = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock_req,
  input  logic [AW-1:0]     lock_rd,
  output logic              lock_ack,
  input  logic              rel_en,
  input  logic [AW-1:0]     rel_rd,
  input  logic [NSP-1:0]    sp_lock,
  input  logic [NSP-1:0]    sp_rel,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP-1:0]    rd_allow,
  input  logic [NSP-1:0]    sp_query,
  output logic              sp_allow,
  input  logic              flush,
  output logic              any_pending,
  output logic              err_underflow
);

  localparam logic [CW-1:0] CntMax = '1;

  // Register 0 is hardwired and has no counter.
  logic [CW-1:0]  cnt_q [1:NREG-1];
  logic [CW-1:0]  cnt_d [1:NREG-1];
  logic [NSP-1:0] sp_q, sp_d;
  logic           err_q;
  logic           underflow;
  logic [CW-1:0]  lock_cnt;
  logic [CW-1:0]  rd_cnt [NRP];
  logic [AW-1:0]  rd_a   [NRP];

  always_comb begin
    lock_cnt = '0;
    for (int i = 1; i < NREG; i++) begin
      if (lock_rd == AW'(i)) lock_cnt = cnt_q[i];
    end
  end

  // A full counter still accepts a lock when the same register retires this cycle.
  assign lock_ack = lock_req && !flush &&
                    ((lock_rd == '0) || (lock_cnt != CntMax) || (rel_en && (rel_rd == lock_rd)));

  always_comb begin
    for (int k = 0; k < NRP; k++) begin
      rd_a[k]   = rd_addr[k*AW +: AW];
      rd_cnt[k] = '0;
      for (int i = 1; i < NREG; i++) begin
        if (rd_a[k] == AW'(i)) rd_cnt[k] = cnt_q[i];
      end
      rd_allow[k] = (rd_a[k] == '0) || (rd_cnt[k] == '0) ||
                    ((rd_cnt[k] == CW'(1)) && rel_en && (rel_rd == rd_a[k]));
    end
  end

  assign sp_allow = &(~sp_query | ~sp_q | sp_rel);

  always_comb begin
    underflow = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (lock_ack && (lock_rd == AW'(i)) && rel_en && (rel_rd == AW'(i))) begin
        cnt_d[i] = cnt_q[i];
      end else if (lock_ack && (lock_rd == AW'(i))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (rel_en && (rel_rd == AW'(i))) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
        else                underflow = 1'b1;
      end
    end
  end

  // Lock wins over a same-cycle release of a special register.
  assign sp_d = flush ? '0 : ((sp_q & ~sp_rel) | sp_lock);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) cnt_q[i] <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      sp_q  <= sp_d;
      err_q <= err_q | underflow;
    end
  end

  always_comb begin
    any_pending = |sp_q;
    for (int i = 1; i < NREG; i++) any_pending = any_pending | (|cnt_q[i]);
  end

  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: stimulus queues expectations, a negedge monitor checks them.
module tb_reg_scoreboard;

  localparam int unsigned NREG = 32;
  localparam int unsigned NRP  = 2;
  localparam int unsigned NSP  = 6;
  localparam int unsigned CW   = 2;
  localparam int unsigned AW   = 5;

  localparam int SAck = 0, SRd = 1, SSp = 2, SAny = 3, SErr = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              lock_req;
  logic [AW-1:0]     lock_rd;
  logic              lock_ack;
  logic              rel_en;
  logic [AW-1:0]     rel_rd;
  logic [NSP-1:0]    sp_lock;
  logic [NSP-1:0]    sp_rel;
  logic [NRP*AW-1:0] rd_addr;
  logic [NRP-1:0]    rd_allow;
  logic [NSP-1:0]    sp_query;
  logic              sp_allow;
  logic              flush;
  logic              any_pending;
  logic              err_underflow;

  reg_scoreboard #(.NREG(NREG), .NRP(NRP), .NSP(NSP), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .lock_req     (lock_req),
    .lock_rd      (lock_rd),
    .lock_ack     (lock_ack),
    .rel_en       (rel_en),
    .rel_rd       (rel_rd),
    .sp_lock      (sp_lock),
    .sp_rel       (sp_rel),
    .rd_addr      (rd_addr),
    .rd_allow     (rd_allow),
    .sp_query     (sp_query),
    .sp_allow     (sp_allow),
    .flush        (flush),
    .any_pending  (any_pending),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] get_sig(int s);
    case (s)
      SAck:    return {7'd0, lock_ack};
      SRd:     return {6'd0, rd_allow};
      SSp:     return {7'd0, sp_allow};
      SAny:    return {7'd0, any_pending};
      default: return {7'd0, err_underflow};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = get_sig(e.sig);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic expect_v(input string name, input int sig, input logic [7:0] val);
    q.push_back('{name, sig, val});
  endtask

  task automatic idle();
    lock_req = 1'b0; lock_rd  = '0; rel_en  = 1'b0; rel_rd = '0;
    sp_lock  = '0;   sp_rel   = '0; rd_addr = '0;   sp_query = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a1, input int a0);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Post-reset state
    idle(); set_rd(7, 5); sp_query = '1;
    expect_v("rst_rd_allow", SRd, 8'h3);
    expect_v("rst_sp_allow", SSp, 8'h1);
    expect_v("rst_any", SAny, 8'h0);
    expect_v("rst_err", SErr, 8'h0);
    #1;
    checks++;
    if (rd_allow !== 2'b11) begin
      errors++;
      $display("FAIL rst_rd_allow_direct: got %0h expected 3 at %0t", rd_allow, $time);
    end
    tick();

    // Saturate r5
    for (int i = 0; i < 3; i++) begin
      idle(); lock_req = 1'b1; lock_rd = 5'd5;
      expect_v("r5_lock_ack", SAck, 8'h1);
      tick();
    end
    idle(); lock_req = 1'b1; lock_rd = 5'd5; set_rd(0, 5);
    expect_v("r5_full_ack", SAck, 8'h0);
    expect_v("r5_busy_allow", SRd, 8'h2);
    expect_v("r5_any", SAny, 8'h1);
    #1;
    checks++;
    if (lock_ack !== 1'b0) begin
      errors++;
      $display("FAIL r5_full_ack_direct: got %0b expected 0 at %0t", lock_ack, $time);
    end
    tick();
    for (int j = 0; j < 3; j++) begin
      idle(); rel_en = 1'b1; rel_rd = 5'd5; set_rd(0, 5);
      expect_v("r5_drain_allow", SRd, (j == 2) ? 8'h3 : 8'h2);
      tick();
    end
    idle(); set_rd(0, 5);
    expect_v("r5_free_allow", SRd, 8'h3);
    expect_v("r5_free_any", SAny, 8'h0);
    expect_v("r5_free_err", SErr, 8'h0);
    tick();

    // Writeback bypass on r7
    idle(); lock_req = 1'b1; lock_rd = 5'd7;
    expect_v("r7_lock_ack", SAck, 8'h1);
    tick();
    idle(); set_rd(0, 7);
    expect_v("r7_busy_allow", SRd, 8'h2);
    tick();
    idle(); set_rd(7, 7); rel_en = 1'b1; rel_rd = 5'd7;
    expect_v("r7_bypass_allow", SRd, 8'h3);
    #1;
    checks++;
    if (rd_allow !== 2'b11) begin
      errors++;
      $display("FAIL r7_bypass_direct: got %0h expected 3 at %0t", rd_allow, $time);
    end
    tick();
    idle(); set_rd(7, 7);
    expect_v("r7_after_allow", SRd, 8'h3);
    expect_v("r7_after_any", SAny, 8'h0);
    tick();

    // Lock+release on a full r9
    for (int i = 0; i < 3; i++) begin
      idle(); lock_req = 1'b1; lock_rd = 5'd9;
      expect_v("r9_lock_ack", SAck, 8'h1);
      tick();
    end
    idle(); lock_req = 1'b1; lock_rd = 5'd9; rel_en = 1'b1; rel_rd = 5'd9;
    expect_v("r9_full_relock_ack", SAck, 8'h1);
    #1;
    checks++;
    if (lock_ack !== 1'b1) begin
      errors++;
      $display("FAIL r9_relock_direct: got %0b expected 1 at %0t", lock_ack, $time);
    end
    tick();
    idle(); lock_req = 1'b1; lock_rd = 5'd9;
    expect_v("r9_still_full_ack", SAck, 8'h0);
    tick();
    for (int j = 0; j < 3; j++) begin
      idle(); rel_en = 1'b1; rel_rd = 5'd9; set_rd(9, 0);
      expect_v("r9_drain_allow", SRd, (j == 2) ? 8'h3 : 8'h1);
      tick();
    end
    idle(); set_rd(9, 9);
    expect_v("r9_free_allow", SRd, 8'h3);
    expect_v("r9_free_any", SAny, 8'h0);
    expect_v("r9_free_err", SErr, 8'h0);
    tick();

    // r0 never locks
    idle(); lock_req = 1'b1; lock_rd = 5'd0; set_rd(0, 0);
    expect_v("r0_lock_ack", SAck, 8'h1);
    tick();
    idle(); set_rd(0, 0);
    expect_v("r0_allow", SRd, 8'h3);
    expect_v("r0_any", SAny, 8'h0);
    tick();

    // Underflow on r4
    idle(); rel_en = 1'b1; rel_rd = 5'd4;
    expect_v("uf_before", SErr, 8'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      expect_v("uf_sticky", SErr, 8'h1);
      tick();
    end
    idle(); reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    expect_v("uf_cleared", SErr, 8'h0);
    #1;
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_cleared_direct: got %0b expected 0 at %0t", err_underflow, $time);
    end
    tick();

    // Reset mid-operation discards a pending lock
    idle(); lock_req = 1'b1; lock_rd = 5'd6;
    expect_v("r6_lock_ack", SAck, 8'h1);
    tick();
    idle(); reset = 1'b1;
    expect_v("r6_any_before", SAny, 8'h1);
    tick();
    reset = 1'b0;
    idle(); set_rd(0, 6);
    expect_v("r6_rst_allow", SRd, 8'h3);
    expect_v("r6_rst_any", SAny, 8'h0);
    tick();

    // Special register: lock wins over simultaneous release, then release bypass
    idle(); sp_lock = 6'b000001; sp_rel = 6'b000001;
    tick();
    idle(); sp_query = 6'b000001;
    expect_v("sp_set_allow", SSp, 8'h0);
    expect_v("sp_set_any", SAny, 8'h1);
    tick();
    idle(); sp_query = 6'b000001; sp_rel = 6'b000001;
    expect_v("sp_rel_bypass", SSp, 8'h1);
    tick();
    idle(); sp_query = 6'b000001;
    expect_v("sp_clr_allow", SSp, 8'h1);
    expect_v("sp_clr_any", SAny, 8'h0);
    tick();

    // Flush clears everything and refuses a same-cycle lock
    for (int i = 0; i < 2; i++) begin
      idle(); lock_req = 1'b1; lock_rd = 5'd3;
      expect_v("r3_lock_ack", SAck, 8'h1);
      tick();
    end
    idle(); lock_req = 1'b1; lock_rd = 5'd8; sp_lock = 6'b001000;
    expect_v("r8_lock_ack", SAck, 8'h1);
    tick();
    idle(); set_rd(8, 3); sp_query = 6'b001000;
    expect_v("fl_pre_rd", SRd, 8'h0);
    expect_v("fl_pre_sp", SSp, 8'h0);
    expect_v("fl_pre_any", SAny, 8'h1);
    tick();
    idle(); flush = 1'b1; lock_req = 1'b1; lock_rd = 5'd2;
    expect_v("fl_lock_ack", SAck, 8'h0);
    #1;
    checks++;
    if (lock_ack !== 1'b0) begin
      errors++;
      $display("FAIL fl_lock_ack_direct: got %0b expected 0 at %0t", lock_ack, $time);
    end
    tick();
    idle(); set_rd(8, 3); sp_query = '1;
    expect_v("fl_post_rd", SRd, 8'h3);
    expect_v("fl_post_sp", SSp, 8'h1);
    expect_v("fl_post_any", SAny, 8'h0);
    tick();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0 || checks < 12) begin
      $display("FAIL summary: got %0d errors in %0d checks expected 0 errors", errors, checks);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: number of general registers, power of two, >=2.
REQ-002 SHALL have parameter NRP, default 2: number of read-query ports.
REQ-003 SHALL have parameter NSP, default 6: number of special registers (HI, LO, BadVAddr, Status, Cause, EPC by default).
REQ-004 SHALL have parameter CW, default 2: width of the per-register pending-write counter; MAX = 2^CW-1.
REQ-005 SHALL derive AW = log2(NREG).
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port lock_req, input, 1: decode requests one more pending write to lock_rd.
REQ-009 SHALL have port lock_rd, input, AW: destination register to lock.
REQ-010 SHALL have port lock_ack, output, 1: lock request accepted this cycle.
REQ-011 SHALL have port rel_en, input, 1: writeback retires one pending write to rel_rd.
REQ-012 SHALL have port rel_rd, input, AW: register being released.
REQ-013 SHALL have port sp_lock, input, NSP: one-hot-or-zero special-register lock requests.
REQ-014 SHALL have port sp_rel, input, NSP: special-register release strobes.
REQ-015 SHALL have port rd_addr, input, NRP*AW: packed query addresses, port k at bits [k*AW +: AW].
REQ-016 SHALL have port rd_allow, output, NRP: bit k = source for port k is hazard-free.
REQ-017 SHALL have port sp_query, input, NSP: special registers the current instruction reads.
REQ-018 SHALL have port sp_allow, output, 1: all queried special registers are free.
REQ-019 SHALL have port flush, input, 1: pipeline flush on exception/jump.
REQ-020 SHALL have port any_pending, output, 1: some counter or special lock is nonzero.
REQ-021 SHALL have port err_underflow, output, 1: sticky flag, release of an unlocked register.

Function
REQ-022 SHALL keep one CW-bit counter per general register 1..NREG-1; register 0 SHALL have no counter, SHALL never lock, and SHALL always report allowed.
REQ-023 SHALL keep one 1-bit lock per special register.
REQ-024 SHALL assert lock_ack combinationally when lock_req=1 and lock_rd=0, or when lock_req=1 and cnt[lock_rd]<MAX.
REQ-025 SHALL also assert lock_ack when lock_req=1, cnt[lock_rd]=MAX, and rel_en=1 with rel_rd=lock_rd in the same cycle.
REQ-026 SHALL, on a cycle with lock_req=1 and lock_ack=0, leave the counter unchanged; decode stalls and retries.
REQ-027 SHALL update the counter on an accepted lock only (no release to the same register): cnt+1.
REQ-028 SHALL update the counter on a release only, with cnt>0: cnt-1.
REQ-029 SHALL leave the counter unchanged when an accepted lock and a release hit the same register in the same cycle.
REQ-030 SHALL update both counters independently when lock and release hit different registers.
REQ-031 SHALL, on a release with cnt=0 and rel_rd!=0, change no counter and set err_underflow on the next edge; err_underflow SHALL then hold until reset.
REQ-032 SHALL drive rd_allow[k]=1 when rd_addr[k]=0, or cnt=0, or (cnt=1 and rel_en=1 and rel_rd=rd_addr[k]), i.e. same-cycle writeback bypass.
REQ-033 SHALL set special bit i on sp_lock[i] and clear it on sp_rel[i]; when both are asserted in the same cycle the bit SHALL stay at 1.
REQ-034 SHALL drive sp_allow = AND over i of (~sp_query[i] | ~sp_bit[i] | sp_rel[i]).
REQ-035 SHALL, on flush=1, clear all counters and special bits on the next edge, ignore every lock and release in that cycle, and drive lock_ack=0 that cycle.
REQ-036 SHALL drive any_pending registered-state-only: OR of all counters and special bits, with no bypass.
REQ-037 SHALL make lock_ack, rd_allow and sp_allow combinational from current state plus same-cycle inputs; all other outputs SHALL come from registered state.

Reset
REQ-038 SHALL, on reset=1 at a rising edge, clear all counters, special bits and err_underflow; reset SHALL take priority over flush, lock and release.
REQ-039 SHALL, after reset, present rd_allow all-ones, sp_allow=1, any_pending=0 and err_underflow=0.
REQ-040 SHALL, when reset is asserted mid-operation, discard all pending locks; no release arriving later may set err_underflow before such a release would actually underflow.

Verification
REQ-041 SHALL verify: lock r5 for 3 cycles (CW=2) -> cnt=3, lock_ack=1 on each; 4th lock -> lock_ack=0, cnt stays 3.
REQ-042 SHALL verify: cnt[r7]=1 with rd_addr0=7 and rel_en=1 rel_rd=7 -> rd_allow[0]=1 same cycle; next cycle cnt=0.
REQ-043 SHALL verify: cnt[r9]=3 with lock and release of r9 in the same cycle -> lock_ack=1 and cnt stays 3.
REQ-044 SHALL verify: lock r0 -> lock_ack=1, any_pending stays 0, rd_allow for r0 stays 1.
REQ-045 SHALL verify: release r4 with cnt=0 -> err_underflow=1 next cycle and held; reset -> 0.
REQ-046 SHALL verify: r3=2, r8=1, sp_lock Status set, then flush with a simultaneous lock of r2 -> lock_ack=0; next cycle all clear and any_pending=0.
